// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the I/D physical-memory port arbiter.
package pmem_arb_pkg;
  localparam int PMEM_ADDR_W = 32;
  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D, ARB_TURN} arb_state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the side that did not win last time goes.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    if (&req) gnt_id = ~last;
    else      gnt_id = req[1];
  end
endmodule

// File: rtl/pmem_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache; one grant at a
// time, held until mem_resp, followed by a single dead TURN cycle.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);
  arb_state_t state, state_nxt;
  req_id_t    last_grant;
  logic       gnt_valid, gnt_id;

  arb_rr2 u_rr (
    .req      ({d_read | d_write, i_read | i_write}),
    .last     (last_grant),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // last_grant starts at D so the first tie after reset goes to I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_D;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && gnt_valid) last_grant <= req_id_t'(gnt_id);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:    if (gnt_valid) state_nxt = gnt_id ? ARB_GRANT_D : ARB_GRANT_I;
      ARB_GRANT_I,
      ARB_GRANT_D: if (mem_resp) state_nxt = ARB_TURN;
      ARB_TURN:    state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // Requests pass straight through while granted; a dropped request drops the strobe.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    unique case (state)
      ARB_GRANT_I: begin
        mem_read  = i_read;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_resp    = mem_resp;
      end
      ARB_GRANT_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(i_resp && d_resp));
  a_quiet_idle_turn: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_IDLE || state == ARB_TURN) |-> !(mem_read || mem_write || i_resp || d_resp));
  a_i_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(i_read && i_write));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));
endmodule
